zube_mailbox_fifo: RTL

Parametrised successor to the single-byte Zube mailbox. Bridges the Caravel Wishbone slave port to an external 8-bit CPU I/O bus through two byte FIFOs of configurable depth: TX (host to ext) and RX (ext to host). Adds level-threshold and error interrupts. Sits in the user project area, driving GPIO 8..35 and user_irq[1:0].

---
 rtl/zube_mailbox_fifo.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/zube_mailbox_fifo.sv
// Zube mailbox: Wishbone slave <-> external 8-bit CPU bus, bridged by a TX and an RX byte FIFO
// with level-threshold and sticky-error interrupts.
module zube_mailbox_fifo_buf #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            din,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);
    localparam logic [DEPTH_LOG2:0] ONE = 1;

    logic [7:0]          mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wptr, rptr;
    logic                do_push, do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                      (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign level    = wptr - rptr;
    assign head     = mem[rptr[DEPTH_LOG2-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop   = pop & ~empty & ~flush;
    assign do_push  = push & ~flush & (~full | do_pop);
    assign overflow = push & ~flush & full & ~do_pop;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop)  rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
    end
endmodule

module zube_mailbox_fifo #(
    parameter int          DEPTH_LOG2  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic [31:0] wb_data_out,
    input  logic        ext_cs_n_in,
    input  logic        ext_rd_n_in,
    input  logic        ext_wr_n_in,
    input  logic        ext_addr_in,
    input  logic [7:0]  ext_data_in,
    output logic [7:0]  ext_data_out,
    output logic        ext_data_oeb,
    output logic        ext_irq_out,
    output logic        irq_data_out,
    output logic        irq_status_out
);
    localparam int L = DEPTH_LOG2 + 1;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, warm;
    logic                   s_cs, s_rd, s_wr, prev_rd, prev_wr, rd_fall, wr_fall;
    logic                   acc, tx_push, rx_pop, tx_flush, ctrl_wr;
    logic [1:0]             off;
    logic [2:0]             w1c;
    logic [9:0]             ctrl;
    logic                   tx_ovf, rx_unf, ext_ovf;
    logic [7:0]             tx_head, rx_head;
    logic                   tx_empty, tx_full, rx_empty, rx_full, tx_ovf_set, rx_ovf_set;
    logic [L-1:0]           tx_level, rx_level;
    logic [31:0]            tx_lvl32, rx_lvl32, status_word, rdata;
    logic                   unused_bits;

    // Synchronisers idle high; warm marks when the chains hold real samples so a
    // strobe held low across reset is not mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            warm    <= '0;
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], ext_cs_n_in};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], ext_rd_n_in};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], ext_wr_n_in};
            warm    <= {warm[SYNC_STAGES-2:0], 1'b1};
            prev_rd <= s_rd & warm[SYNC_STAGES-1];
            prev_wr <= s_wr & warm[SYNC_STAGES-1];
        end
    end

    assign s_cs         = cs_sync[SYNC_STAGES-1];
    assign s_rd         = rd_sync[SYNC_STAGES-1];
    assign s_wr         = wr_sync[SYNC_STAGES-1];
    assign rd_fall      = prev_rd & ~s_rd & ~s_cs;
    assign wr_fall      = prev_wr & ~s_wr & ~s_cs;
    assign ext_data_oeb = ~(~s_cs & ~s_rd);

    assign acc      = wb_cyc_in & wb_stb_in & ~wb_ack_out & (wb_addr_in[31:4] == BASE_ADDR[31:4]);
    assign off      = wb_addr_in[3:2];
    assign tx_push  = acc & wb_we_in & (off == 2'd0);
    assign rx_pop   = acc & ~wb_we_in & (off == 2'd0);
    assign ctrl_wr  = acc & wb_we_in & (off == 2'd2);
    assign tx_flush = ctrl_wr & wb_data_in[10];
    assign w1c      = (acc & wb_we_in & (off == 2'd1)) ? wb_data_in[3:1] : 3'b000;

    zube_mailbox_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk(clk), .reset_b(reset_b), .push(tx_push), .pop(rd_fall & ~ext_addr_in),
        .flush(tx_flush), .din(wb_data_in[7:0]), .head(tx_head), .empty(tx_empty),
        .full(tx_full), .level(tx_level), .overflow(tx_ovf_set)
    );

    zube_mailbox_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk(clk), .reset_b(reset_b), .push(wr_fall & ~ext_addr_in), .pop(rx_pop),
        .flush(1'b0), .din(ext_data_in), .head(rx_head), .empty(rx_empty),
        .full(rx_full), .level(rx_level), .overflow(rx_ovf_set)
    );

    assign tx_lvl32    = 32'(tx_level);
    assign rx_lvl32    = 32'(rx_level);
    assign status_word = {tx_lvl32[7:0], rx_lvl32[7:0], 12'b0, ext_ovf, rx_unf, tx_ovf, tx_empty};

    always_comb begin
        rdata = '0;
        case (off)
            2'd0:    rdata = rx_empty ? 32'd0 : {23'b0, 1'b1, rx_head};
            2'd1:    rdata = status_word;
            2'd2:    rdata = {22'b0, ctrl};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wb_ack_out  <= 1'b0;
            wb_data_out <= '0;
            ctrl        <= '0;
            tx_ovf      <= 1'b0;
            rx_unf      <= 1'b0;
            ext_ovf     <= 1'b0;
        end else begin
            wb_ack_out  <= acc;
            wb_data_out <= (acc & ~wb_we_in) ? rdata : 32'd0;
            if (ctrl_wr) ctrl <= wb_data_in[9:0];
            // Setting beats a simultaneous write-1-to-clear so no event is lost.
            tx_ovf  <= (tx_ovf  & ~w1c[0]) | tx_ovf_set;
            rx_unf  <= (rx_unf  & ~w1c[1]) | (rx_pop & rx_empty);
            ext_ovf <= (ext_ovf & ~w1c[2]) | rx_ovf_set;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ext_data_out   <= '0;
            ext_irq_out    <= 1'b0;
            irq_data_out   <= 1'b0;
            irq_status_out <= 1'b0;
        end else begin
            if (rd_fall) begin
                if (ext_addr_in)               ext_data_out <= {6'b0, rx_full, ~tx_empty};
                else if (tx_empty | tx_flush)  ext_data_out <= 8'h00;
                else                           ext_data_out <= tx_head;
            end
            ext_irq_out    <= ~tx_empty;
            irq_data_out   <= ctrl[8] & (ctrl[7:0] != 8'd0) & (rx_lvl32 >= {24'b0, ctrl[7:0]});
            irq_status_out <= ctrl[9] & (tx_ovf | rx_unf | ext_ovf);
        end
    end

    assign unused_bits = &{1'b0, wb_addr_in[1:0], wb_data_in[31:11], tx_full};
endmodule
